// File: rtl/x_23k640_model_pkg.sv
// Shared definitions for the 23K640 SPI SRAM responder model and its controller:
// command opcodes, status mode encodings and the responder FSM state type.
package x_23k640_model_pkg;

  localparam logic [7:0] C_READ  = 8'h03;
  localparam logic [7:0] C_WRITE = 8'h02;
  localparam logic [7:0] C_RDSR  = 8'h05;
  localparam logic [7:0] C_WRSR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_RD_SR,
    ST_WR_SR,
    ST_IGNORE
  } state_t;

  // Status register as seen on the wire: mode bits, five zeros, hold-disable bit.
  function automatic logic [7:0] sr_byte(input logic [1:0] mode, input logic hold);
    return {mode, 5'b00000, hold};
  endfunction

endpackage

// File: rtl/x_23k640_model_sync.sv
// Two-flop synchronizer for the SPI pins (sck, cs, si) with single-cycle
// pulses marking the rising and falling edges of the synchronized sck.
module x_23k640_model_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic cs,
  input  logic si,
  output logic cs_sync,
  output logic si_sync,
  output logic sck_rise,
  output logic sck_fall
);

  // Bit 2 = sck, bit 1 = cs, bit 0 = si; cs resets to its idle (deselected) level.
  logic [2:0] meta;
  logic [2:0] sync;
  logic       sck_prev;

  // Two synchronizer stages plus a delayed copy of sck for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 3'b010;
      sync     <= 3'b010;
      sck_prev <= 1'b0;
    end else begin
      meta     <= {sck, cs, si};
      sync     <= meta;
      sck_prev <= sync[2];
    end
  end

  assign cs_sync  = sync[1];
  assign si_sync  = sync[0];
  assign sck_rise = sync[2] & ~sck_prev;
  assign sck_fall = ~sync[2] & sck_prev;

endmodule

// File: rtl/x_23k640_model.sv
// Oversampled responder emulating one 23K640 SPI SRAM (SPI mode 0) with a
// reduced 2**p_addr_w byte memory. Supports READ, WRITE, RDSR and WRSR in
// byte, page and sequential modes.
// Optional: define SRAM_MODEL_STATS_EN to add saturating read/write byte counters.
module x_23k640_model
  import x_23k640_model_pkg::*;
#(
  parameter int p_addr_w = 8,
  parameter int p_page_w = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sck,
  input  logic        i_cs,
  input  logic        i_si,
  output logic        o_so,
  output logic        o_so_oe,
  output logic [1:0]  o_mode
`ifdef SRAM_MODEL_STATS_EN
  ,
  output logic [15:0] o_rd_count,
  output logic [15:0] o_wr_count
`endif
);

  localparam int DEPTH = 2 ** p_addr_w;
  localparam int SHIFT_W = (p_addr_w - 1 > 7) ? p_addr_w - 1 : 7;
  localparam logic [p_addr_w-1:0] ADDR_ONE  = p_addr_w'(1);
  localparam logic [p_addr_w-1:0] PAGE_MASK = p_addr_w'((1 << p_page_w) - 1);

  logic cs_s, si_s, sck_rise, sck_fall;

  state_t state, next_state;

  logic [3:0]          bit_cnt;
  logic [SHIFT_W-1:0]  shift_in;
  logic [7:0]          in_byte;
  logic [p_addr_w-1:0] addr_next;
  logic                is_read;
  logic [p_addr_w-1:0] addr;
  logic [1:0]          mode_q;
  logic                hold_q;
  logic [7:0]          shift_out;
  logic                so_q;
  logic                load_mem;
  logic                rd_active;
  logic                byte_mode;

  logic cmd_done, addr_done, byte_done, mem_we, sr_we;

  logic [7:0] mem [DEPTH];

  x_23k640_model_sync u_sync (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .sck      (i_sck),
    .cs       (i_cs),
    .si       (i_si),
    .cs_sync  (cs_s),
    .si_sync  (si_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // The byte or address being completed on this sck rise includes the live si bit.
  assign in_byte   = {shift_in[6:0], si_s};
  assign addr_next = {shift_in[p_addr_w-2:0], si_s};
  assign byte_mode = (mode_q != MODE_PAGE) && (mode_q != MODE_SEQ);
  assign rd_active = ((state == ST_RD_DATA) || (state == ST_RD_SR)) && !cs_s;

  // Advance a data address: page mode wraps inside the page, sequential wraps the whole array.
  function automatic logic [p_addr_w-1:0] advance(input logic [p_addr_w-1:0] a,
                                                  input logic [1:0] m);
    logic [p_addr_w-1:0] inc;
    inc = a + ADDR_ONE;
    if (m == MODE_SEQ) return inc;
    if (m == MODE_PAGE) return (a & ~PAGE_MASK) | (inc & PAGE_MASK);
    return a;
  endfunction

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state decode and per-bit event strobes; cs high always returns to idle.
  always_comb begin
    next_state = state;
    cmd_done   = 1'b0;
    addr_done  = 1'b0;
    byte_done  = 1'b0;
    mem_we     = 1'b0;
    sr_we      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cs_s) next_state = ST_CMD;
      end
      ST_CMD: begin
        if (sck_rise && bit_cnt == 4'd7) begin
          cmd_done = 1'b1;
          case (in_byte)
            C_READ, C_WRITE: next_state = ST_ADDR;
            C_RDSR:          next_state = ST_RD_SR;
            C_WRSR:          next_state = ST_WR_SR;
            default:         next_state = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: begin
        if (sck_rise && bit_cnt == 4'd15) begin
          addr_done  = 1'b1;
          next_state = is_read ? ST_RD_DATA : ST_WR_DATA;
        end
      end
      ST_RD_DATA: begin
        if (sck_rise && bit_cnt == 4'd7) begin
          byte_done = 1'b1;
          if (byte_mode) next_state = ST_IGNORE;
        end
      end
      ST_WR_DATA: begin
        if (sck_rise && bit_cnt == 4'd7) begin
          byte_done = 1'b1;
          mem_we    = 1'b1;
          if (byte_mode) next_state = ST_IGNORE;
        end
      end
      ST_RD_SR: begin
        if (sck_rise && bit_cnt == 4'd7) byte_done = 1'b1;
      end
      ST_WR_SR: begin
        if (sck_rise && bit_cnt == 4'd7) begin
          sr_we      = 1'b1;
          next_state = ST_IGNORE;
        end
      end
      default: begin
      end
    endcase
    if (cs_s && state != ST_IDLE) next_state = ST_IDLE;
  end

  // Bit counter: 8-bit groups everywhere except the 16-bit address phase.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bit_cnt <= 4'd0;
    end else if (state == ST_IDLE) begin
      bit_cnt <= 4'd0;
    end else if (sck_rise) begin
      if ((state != ST_ADDR && bit_cnt == 4'd7) || bit_cnt == 4'd15) bit_cnt <= 4'd0;
      else                                                        bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Serial input shifter, sampled on each sck rise.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                            shift_in <= '0;
    else if (sck_rise && state != ST_IDLE) shift_in <= {shift_in[SHIFT_W-2:0], si_s};
  end

  // Remember whether the address phase belongs to a read or a write.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)        is_read <= 1'b0;
    else if (cmd_done) is_read <= (in_byte == C_READ);
  end

  // Data address: loaded from the address phase, advanced after every data byte.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                    addr <= '0;
    else if (addr_done)                            addr <= addr_next;
    else if (byte_done && state == ST_RD_DATA)     addr <= advance(addr, mode_q);
    else if (mem_we)                               addr <= advance(addr, mode_q);
  end

  // Status register: mode bits and hold bit, loaded by the first full WRSR byte.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mode_q <= MODE_BYTE;
      hold_q <= 1'b0;
    end else if (sr_we) begin
      mode_q <= in_byte[7:6];
      hold_q <= in_byte[0];
    end
  end

  // Request a memory fetch after the address phase and after each streamed read byte.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) load_mem <= 1'b0;
    else        load_mem <= (addr_done && is_read) ||
                            (state == ST_RD_DATA && byte_done && !byte_mode);
  end

  // Output shifter: registered memory read, status reload, or shift on sck fall.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      shift_out <= 8'h00;
    end else if (load_mem) begin
      shift_out <= mem[addr];
    end else if ((cmd_done && next_state == ST_RD_SR) || (state == ST_RD_SR && byte_done)) begin
      shift_out <= sr_byte(mode_q, hold_q);
    end else if (sck_fall && rd_active) begin
      shift_out <= {shift_out[6:0], 1'b0};
    end
  end

  // Serial output bit, updated one cycle after the detected sck fall.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)          so_q <= 1'b0;
    else if (!rd_active) so_q <= 1'b0;
    else if (sck_fall)   so_q <= shift_out[7];
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[addr] <= in_byte;
  end

  assign o_so_oe = rd_active;
  assign o_so    = rd_active & so_q;
  assign o_mode  = mode_q;

`ifdef SRAM_MODEL_STATS_EN
  // Saturating counts of streamed read bytes and committed memory writes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rd_count <= 16'h0000;
      o_wr_count <= 16'h0000;
    end else begin
      if (byte_done && state == ST_RD_DATA && o_rd_count != 16'hFFFF)
        o_rd_count <= o_rd_count + 16'd1;
      if (mem_we && o_wr_count != 16'hFFFF)
        o_wr_count <= o_wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_x_23k640_model.sv
// Self-checking bench for x_23k640_model: directed scenarios plus randomized
// transactions compared against a byte-level behavioural model of the SRAM.
module tb_x_23k640_model;

  localparam int HALF  = 6;
  localparam int DEPTH = 256;
  localparam int PAGE  = 32;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_sck;
  logic       i_cs;
  logic       i_si;
  logic       o_so;
  logic       o_so_oe;
  logic [1:0] o_mode;
`ifdef SRAM_MODEL_STATS_EN
  logic [15:0] o_rd_count;
  logic [15:0] o_wr_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_buf [16];
  logic [7:0] rx_buf [16];
  logic       oe_hi  [16];
  logic       oe_lo  [16];
  logic [7:0] wr_data [8];

  logic [7:0] model_mem   [DEPTH];
  bit         model_valid [DEPTH];
  logic [7:0] model_sr;

  x_23k640_model dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sck   (i_sck),
    .i_cs    (i_cs),
    .i_si    (i_si),
    .o_so    (o_so),
    .o_so_oe (o_so_oe),
    .o_mode  (o_mode)
`ifdef SRAM_MODEL_STATS_EN
    ,
    .o_rd_count (o_rd_count),
    .o_wr_count (o_wr_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_byte_mode();
    return (model_sr[7:6] != 2'b01) && (model_sr[7:6] != 2'b10);
  endfunction

  function automatic int next_a(input int a);
    if (model_sr[7:6] == 2'b01) return (a + 1) % DEPTH;
    if (model_sr[7:6] == 2'b10) return (a / PAGE) * PAGE + (a + 1) % PAGE;
    return a;
  endfunction

  // One SPI mode-0 bit: drive si while sck low, sample so just before the rise.
  task automatic spi_bit(input logic b, output logic so, output logic oe);
    i_si = b;
    repeat (HALF) @(negedge i_clk);
    so = o_so;
    oe = o_so_oe;
    i_sck = 1'b1;
    repeat (HALF) @(negedge i_clk);
    i_sck = 1'b0;
  endtask

  task automatic applyStimulus(input int nbits, input bit hold_cs);
    logic so_b, oe_b;
    for (int k = 0; k < 16; k++) begin
      rx_buf[k] = 8'h00;
      oe_hi[k]  = 1'b1;
      oe_lo[k]  = 1'b1;
    end
    i_cs = 1'b0;
    repeat (HALF) @(negedge i_clk);
    for (int b = 0; b < nbits; b++) begin
      int k;
      int i;
      k = b / 8;
      i = 7 - (b % 8);
      spi_bit(tx_buf[k][i], so_b, oe_b);
      rx_buf[k][i] = so_b;
      if (!oe_b) oe_hi[k] = 1'b0;
      if (oe_b)  oe_lo[k] = 1'b0;
    end
    if (!hold_cs) begin
      i_cs = 1'b1;
      repeat (10) @(negedge i_clk);
    end
  endtask

  task automatic do_wrsr(input logic [7:0] d);
    tx_buf[0] = 8'h01;
    tx_buf[1] = d;
    tx_buf[2] = ~d;
    applyStimulus(24, 1'b0);
    model_sr = d & 8'hC1;
    checkOutput("wrsr_mode", 32'(o_mode), 32'(model_sr[7:6]));
  endtask

  task automatic do_rdsr(input int n);
    tx_buf[0] = 8'h05;
    for (int k = 1; k <= n; k++) tx_buf[k] = 8'($urandom_range(0, 255));
    applyStimulus((n + 1) * 8, 1'b0);
    checkOutput("rdsr_cmd_oe_low", 32'(oe_lo[0]), 1);
    for (int k = 1; k <= n; k++) begin
      checkOutput("rdsr_data", 32'(rx_buf[k]), 32'(model_sr));
      checkOutput("rdsr_oe_high", 32'(oe_hi[k]), 1);
    end
    checkOutput("rdsr_oe_after_cs", 32'(o_so_oe), 0);
  endtask

  task automatic do_write(input logic [15:0] a16, input int n);
    int a;
    tx_buf[0] = 8'h02;
    tx_buf[1] = a16[15:8];
    tx_buf[2] = a16[7:0];
    for (int k = 0; k < n; k++) tx_buf[3 + k] = wr_data[k];
    applyStimulus((3 + n) * 8, 1'b0);
    a = int'(a16) % DEPTH;
    for (int k = 0; k < n; k++) begin
      model_mem[a]   = wr_data[k];
      model_valid[a] = 1'b1;
      if (model_byte_mode()) break;
      a = next_a(a);
    end
  endtask

  task automatic do_read(input logic [15:0] a16, input int n);
    int a;
    tx_buf[0] = 8'h03;
    tx_buf[1] = a16[15:8];
    tx_buf[2] = a16[7:0];
    for (int k = 0; k < n; k++) tx_buf[3 + k] = 8'($urandom_range(0, 255));
    applyStimulus((3 + n) * 8, 1'b0);
    checkOutput("rd_cmd_oe_low", 32'(oe_lo[0]), 1);
    a = int'(a16) % DEPTH;
    for (int k = 0; k < n; k++) begin
      if (model_byte_mode() && k > 0) begin
        checkOutput("rd_extra_data", 32'(rx_buf[3 + k]), 0);
        checkOutput("rd_extra_oe_low", 32'(oe_lo[3 + k]), 1);
      end else begin
        checkOutput("rd_oe_high", 32'(oe_hi[3 + k]), 1);
        if (model_valid[a]) checkOutput("rd_data", 32'(rx_buf[3 + k]), 32'(model_mem[a]));
        a = next_a(a);
      end
    end
    checkOutput("rd_oe_after_cs", 32'(o_so_oe), 0);
  endtask

  initial begin
    logic [15:0] addr16;
    logic [7:0]  old40;

    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
    model_sr = 8'h00;

    i_rst = 1'b0;
    i_cs  = 1'b1;
    i_sck = 1'b0;
    i_si  = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_so", 32'(o_so), 0);
    checkOutput("reset_oe", 32'(o_so_oe), 0);
    checkOutput("reset_mode", 32'(o_mode), 0);
`ifdef SRAM_MODEL_STATS_EN
    checkOutput("reset_rd_count", 32'(o_rd_count), 0);
    checkOutput("reset_wr_count", 32'(o_wr_count), 0);
`endif
    i_rst = 1'b1;
    repeat (5) @(negedge i_clk);

    $display("[TB] status read after reset");
    do_rdsr(1);

    $display("[TB] byte mode write and read");
    wr_data[0] = 8'hA5;
    wr_data[1] = 8'h3C;
    do_write(16'h0010, 2);
    do_read(16'h0010, 2);
    checkOutput("byte_mode_value", 32'(rx_buf[3]), 32'h00A5);

    $display("[TB] sequential mode with wrap");
    do_wrsr(8'h40);
    checkOutput("seq_mode_pin", 32'(o_mode), 32'h1);
    do_rdsr(2);
    wr_data[0] = 8'h11;
    wr_data[1] = 8'h22;
    wr_data[2] = 8'h33;
    do_write(16'h00FE, 3);
    do_read(16'h00FE, 2);
    do_read(16'h0000, 1);
    checkOutput("seq_wrap_value", 32'(rx_buf[3]), 32'h0033);
    wr_data[0] = 8'h99;
    do_write(16'h0020, 1);

    $display("[TB] page mode with wrap");
    do_wrsr(8'h80);
    wr_data[0] = 8'h5A;
    wr_data[1] = 8'hC3;
    do_write(16'h001F, 2);
    do_read(16'h001F, 2);
    checkOutput("page_wrap_value", 32'(rx_buf[4]), 32'h00C3);
    do_read(16'h0020, 1);
    checkOutput("page_untouched", 32'(rx_buf[3]), 32'h0099);

    $display("[TB] partial byte write is discarded");
    do_wrsr(8'h00);
    old40 = 8'($urandom_range(0, 255));
    if (old40 == 8'h77) old40 = 8'h76;
    wr_data[0] = old40;
    do_write(16'h0040, 1);
    tx_buf[0] = 8'h02;
    tx_buf[1] = 8'h00;
    tx_buf[2] = 8'h40;
    tx_buf[3] = 8'h77;
    applyStimulus(28, 1'b0);
    do_read(16'h0040, 1);
    checkOutput("partial_keeps_old", 32'(rx_buf[3]), 32'(old40));

    $display("[TB] unknown command");
    tx_buf[0] = 8'h9F;
    tx_buf[1] = 8'h00;
    tx_buf[2] = 8'hFF;
    applyStimulus(24, 1'b0);
    for (int k = 0; k < 3; k++) checkOutput("unknown_cmd_oe_low", 32'(oe_lo[k]), 1);

    $display("[TB] randomized transactions");
    for (int it = 0; it < 30; it++) begin
      int op;
      op = $urandom_range(0, 3);
      addr16[15:8] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) addr16[7:0] = 8'(32'hF8 + $urandom_range(0, 7));
      else                           addr16[7:0] = 8'(32'h1A + $urandom_range(0, 7));
      case (op)
        0: do_wrsr(8'($urandom_range(0, 255)));
        1: begin
          for (int k = 0; k < 8; k++) wr_data[k] = 8'($urandom_range(0, 255));
          do_write(addr16, $urandom_range(1, 4));
        end
        2: do_read(addr16, $urandom_range(1, 4));
        default: do_rdsr($urandom_range(1, 3));
      endcase
    end

    $display("[TB] reset during read");
    do_wrsr(8'h40);
    wr_data[0] = 8'hFF;
    do_write(16'h0050, 1);
    tx_buf[0] = 8'h03;
    tx_buf[1] = 8'h00;
    tx_buf[2] = 8'h50;
    tx_buf[3] = 8'h00;
    applyStimulus(27, 1'b1);
    checkOutput("pre_reset_oe", 32'(o_so_oe), 1);
    i_rst = 1'b0;
    #1;
    checkOutput("midreset_so", 32'(o_so), 0);
    checkOutput("midreset_oe", 32'(o_so_oe), 0);
    repeat (4) @(negedge i_clk);
    checkOutput("midreset_so_hold", 32'(o_so), 0);
    checkOutput("midreset_oe_hold", 32'(o_so_oe), 0);
    checkOutput("midreset_mode", 32'(o_mode), 0);
`ifdef SRAM_MODEL_STATS_EN
    checkOutput("midreset_rd_count", 32'(o_rd_count), 0);
    checkOutput("midreset_wr_count", 32'(o_wr_count), 0);
`endif
    i_rst = 1'b1;
    i_cs  = 1'b1;
    repeat (10) @(negedge i_clk);
    model_sr = 8'h00;
    do_rdsr(1);
    do_read(16'h0050, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
